// File: rtl/mux_func_gen.sv
// Reprogrammable mux-based logic-function generator: a 2**SEL_W-entry truth table
// feeds a registered selector. Optional hit counter enabled by MUXFG_HIT_COUNT_EN.
module mux_func_gen #(
  parameter int SEL_W = 3,
  parameter logic [(2**SEL_W)-1:0] RESET_TT = {(2**SEL_W){1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             strobe_n,
  output logic             y,
  output logic             out_valid,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_busy,
  output logic             cfg_done
`ifdef MUXFG_HIT_COUNT_EN
  ,
  input  logic             hit_clr,
  output logic [15:0]      hit_cnt
`endif
);

  localparam int TT_W  = 2**SEL_W;
  localparam int CNT_W = $clog2(TT_W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  cfg_state_t        state_r;
  logic [TT_W-1:0]   shadow_r;
  logic [TT_W-1:0]   active_tt_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              cfg_busy_r;
  logic              cfg_done_r;
  logic              y_r;
  logic              out_valid_r;

  logic [TT_W-1:0]   shadow_restart_s;
  logic [CNT_W-1:0]  cnt_restart_s;
  logic              last_bit_s;

  // A restart may coincide with the first bit of the new load.
  assign shadow_restart_s = {{(TT_W-1){1'b0}}, cfg_valid & cfg_bit};
  assign cnt_restart_s    = {{(CNT_W-1){1'b0}}, cfg_valid};
  assign last_bit_s       = (bit_cnt_r == CNT_W'(TT_W - 1));

  // Serial table load: shift into shadow, then swap into the active table in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shadow_r    <= {TT_W{1'b0}};
      active_tt_r <= RESET_TT;
      bit_cnt_r   <= {CNT_W{1'b0}};
      cfg_busy_r  <= 1'b0;
      cfg_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cfg_done_r <= 1'b0;
          if (cfg_start) begin
            state_r    <= SHIFT;
            shadow_r   <= {TT_W{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            cfg_busy_r <= 1'b1;
          end else begin
            cfg_busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          cfg_busy_r <= 1'b1;
          if (cfg_start) begin
            shadow_r   <= shadow_restart_s;
            bit_cnt_r  <= cnt_restart_s;
            cfg_done_r <= 1'b0;
          end else if (cfg_valid) begin
            shadow_r  <= {shadow_r[TT_W-2:0], cfg_bit};
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            if (last_bit_s) begin
              state_r    <= COMMIT;
              cfg_done_r <= 1'b1;
            end else begin
              cfg_done_r <= 1'b0;
            end
          end else begin
            cfg_done_r <= 1'b0;
          end
        end
        COMMIT: begin
          active_tt_r <= shadow_r;
          state_r     <= IDLE;
          bit_cnt_r   <= {CNT_W{1'b0}};
          cfg_busy_r  <= 1'b0;
          cfg_done_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          bit_cnt_r  <= {CNT_W{1'b0}};
          cfg_busy_r <= 1'b0;
          cfg_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Evaluation pipeline: one-cycle latency, y holds between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        y_r <= strobe_n ? 1'b0 : active_tt_r[sel];
      end else begin
        y_r <= y_r;
      end
    end
  end

  assign y         = y_r;
  assign out_valid = out_valid_r;
  assign cfg_busy  = cfg_busy_r;
  assign cfg_done  = cfg_done_r;

`ifdef MUXFG_HIT_COUNT_EN
  logic [15:0] hit_cnt_r;

  // Saturating count of valid results equal to 1; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r <= 16'h0000;
    end else if (hit_clr) begin
      hit_cnt_r <= 16'h0000;
    end else if (out_valid_r && y_r && (hit_cnt_r != 16'hFFFF)) begin
      hit_cnt_r <= hit_cnt_r + 16'h0001;
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  assign hit_cnt = hit_cnt_r;
`endif

endmodule

// File: tb/tb_mux_func_gen.sv
// Scoreboard bench for mux_func_gen with SEL_W=2, RESET_TT=4'b0110.
// Hit-counter checks run only when MUXFG_HIT_COUNT_EN is defined.
module tb_mux_func_gen;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] sel;
  logic       strobe_n;
  logic       y;
  logic       out_valid;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_busy;
  logic       cfg_done;
`ifdef MUXFG_HIT_COUNT_EN
  logic        hit_clr;
  logic [15:0] hit_cnt;
`endif

  int   n_cmp;
  int   n_err;
  int   done_cnt;
  logic last_y;
  logic exp_q[$];

  mux_func_gen #(
    .SEL_W   (2),
    .RESET_TT(4'b0110)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .sel      (sel),
    .strobe_n (strobe_n),
    .y        (y),
    .out_valid(out_valid),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done)
`ifdef MUXFG_HIT_COUNT_EN
    ,
    .hit_clr  (hit_clr),
    .hit_cnt  (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, push expectation, then score the result at the negedge.
  task automatic cycle(input logic iv, input logic [1:0] s, input logic sn,
                       input logic cs, input logic cv, input logic cb, input logic ey);
    logic e;
    in_valid  = iv;
    sel       = s;
    strobe_n  = sn;
    cfg_start = cs;
    cfg_valid = cv;
    cfg_bit   = cb;
    if (iv) exp_q.push_back(ey);
    @(posedge clk);
    @(negedge clk);
    if (cfg_done) done_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("y", 32'(y), 32'(e));
      last_y = e;
    end else begin
      check_eq("out_valid_idle", 32'(out_valid), 32'd0);
      check_eq("y_hold", 32'(y), 32'(last_y));
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_cnt = 0; last_y = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; strobe_n = 1'b0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
`ifdef MUXFG_HIT_COUNT_EN
    hit_clr = 1'b0;
`endif
    #12;
    check_eq("rst_y", 32'(y), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(cfg_busy), 32'd0);
    check_eq("rst_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset table 0110 evaluated over all selects.
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Strobe inactive forces 0, then idle holds.
    cycle(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load 1000 with gaps while evaluating sel=3 each cycle.
    done_cnt = 0;
    cycle(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("busy_after_start", 32'(cfg_busy), 32'd1);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("done_in_commit", 32'(cfg_done), 32'd1);
    check_eq("busy_in_commit", 32'(cfg_busy), 32'd1);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("busy_after_commit", 32'(cfg_busy), 32'd0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    // cfg_valid in IDLE must not disturb the table.
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("idle_cfg_busy", 32'(cfg_busy), 32'd0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Mid-load restart: 1,1 then restart carrying bit 0, then 0,0,1 -> 0001.
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("restart_no_early_done", 32'(cfg_done), 32'd0);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("restart_done", 32'(cfg_done), 32'd1);
    // cfg_start during COMMIT is ignored.
    cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("start_in_commit_ignored", 32'(cfg_busy), 32'd0);
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a load, with y=1 beforehand.
    cycle(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(cfg_busy), 32'd0);
    check_eq("midrst_y", 32'(y), 32'd0);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    last_y = 1'b0;
    in_valid = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_busy", 32'(cfg_busy), 32'd0);

`ifdef MUXFG_HIT_COUNT_EN
    hit_clr = 1'b1;
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hit_clr = 1'b0;
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("hit_cnt_3", 32'(hit_cnt), 32'd3);
    hit_clr = 1'b1;
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hit_clr = 1'b0;
    check_eq("hit_clr_prio", 32'(hit_cnt), 32'd0);
    in_valid = 1'b1; sel = 2'd1; strobe_n = 1'b0;
    repeat (65540) @(posedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    last_y = 1'b1;
    check_eq("hit_cnt_sat", 32'(hit_cnt), 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_func_gen.md
Name: mux_func_gen

Overview:
- Parametrised, reprogrammable mux-based logic-function generator: a 2^SEL_W-entry truth table drives a registered N-to-1 selector, generalising the fixed 4-input-mux function builders in the lab designs.
- Table is loaded serially through a small config FSM into a shadow register and committed atomically.
- Evaluation path has a 1-cycle registered valid/output handshake and an active-low strobe.

Parameters:
- SEL_W, 3, number of function inputs (select width); legal 1..6; table width TT_W = 2**SEL_W (localparam).
- RESET_TT, {TT_W{1'b0}}, active truth table loaded on reset; bit i is the output for sel == i.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  evaluation request this cycle.
- sel  in  SEL_W  function input vector (MSB = first variable).
- strobe_n  in  1  active-low enable; when 1, result forced to 0.
- y  out  1  registered function result.
- out_valid  out  1  y valid this cycle.
- cfg_start  in  1  pulse: begin a serial table load.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  serial table bit, MSB (tt[TT_W-1]) first.
- cfg_busy  out  1  high from the cycle after cfg_start until commit completes.
- cfg_done  out  1  one-cycle pulse on the commit cycle.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): active_tt=RESET_TT, shadow=0, bit counter=0, FSM=IDLE, y=0, out_valid=0, cfg_busy=0, cfg_done=0. Reset mid-load discards the partial table; active_tt returns to RESET_TT.
- Evaluation: if in_valid at edge k, then at edge k+1: out_valid=1, y = strobe_n ? 0 : active_tt[sel]. If in_valid=0, out_valid=0 and y holds its last value. Back-to-back requests are accepted every cycle; no backpressure.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: cfg_start -> SHIFT; counter cleared; cfg_busy=1 next cycle.
  - SHIFT: each cfg_valid shifts cfg_bit into shadow LSB (shadow <= {shadow[TT_W-2:0], cfg_bit}) and increments the counter (width clog2(TT_W)+1). When the TT_W-th bit is accepted -> COMMIT. cfg_valid=0 stalls without a timeout.
  - COMMIT: active_tt <= shadow; cfg_done=1 for that cycle; -> IDLE; cfg_busy drops the following cycle.
- cfg_start while in SHIFT: restart. Counter and shadow are cleared and the FSM stays in SHIFT. If cfg_valid arrives in the same cycle, that bit is the first bit of the new load.
- cfg_start in COMMIT: ignored; the commit completes.
- cfg_valid in IDLE: ignored; table unchanged.
- Evaluation during SHIFT uses the old active_tt. An evaluation accepted on the COMMIT edge uses the old table. Requests accepted from the next edge use the new table. There is never a mixed table.

Optional Feature:
- Macro MUXFG_HIT_COUNT_EN. When defined, adds two ports:
  - hit_clr  in  1  synchronous clear of the counter.
  - hit_cnt  out  16  evaluations with result 1.
- Counter behaviour: hit_cnt increments on every cycle where out_valid=1 and y=1, and saturates at 16'hFFFF. hit_clr has priority over increment. Reset value is 0.
- When undefined, neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- SEL_W=2, RESET_TT=4'b0110; reset, then in_valid with sel=0..3 on consecutive cycles, strobe_n=0 -> out_valid=1 each following cycle, y = 0,1,1,0.
- Same setup, strobe_n=1, sel=2 -> out_valid=1, y=0. Then in_valid=0 -> out_valid=0, y holds 0.
- Load 4'b1000 (bits 1,0,0,0 with gaps of cfg_valid=0) while evaluating sel=3 every cycle -> y=0 until the COMMIT edge (inclusive), y=1 from the next request; cfg_done exactly one pulse.
- Mid-load restart: send 1,1, then cfg_start with cfg_valid=1, bit=0, followed by 0,0,1 -> committed table 4'b0001; sel=0 gives y=1.
- Assert rst_n=0 after 2 bits of a load -> cfg_busy=0, y=0, out_valid=0 immediately; after release, sel=1 gives y=1 (RESET_TT).
- With MUXFG_HIT_COUNT_EN: 3 hits, then hit_clr together with a hit -> hit_cnt 3 then 0; preload near 16'hFFFF via hits -> holds at 16'hFFFF.
